// File: rtl/muldiv_unit_pkg.sv
// rtl/muldiv_unit_pkg.sv - shared width, operation and state types for the mul/div unit
package muldiv_unit_pkg;

   localparam int WIDTH = 32;

   typedef enum logic [1:0] {
      MULT  = 2'd0,
      MULTU = 2'd1,
      DIV   = 2'd2,
      DIVU  = 2'd3
   } muldiv_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } muldiv_state_e;

   // Two's-complement magnitude; 0x80000000 maps to itself, which reads correctly as unsigned.
   function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
      return v[WIDTH-1] ? -v : v;
   endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// rtl/muldiv_datapath.sv - shift-add multiply / restoring divide accumulator with sign fixup
module muldiv_datapath
   import muldiv_unit_pkg::*;
(
   input  logic             clk,
   input  logic             nrst,
   input  logic             load,
   input  logic             step,
   input  muldiv_op_e       op,
   input  logic [WIDTH-1:0] rs_data,
   input  logic [WIDTH-1:0] rt_data,
   output logic [WIDTH-1:0] res_hi,
   output logic [WIDTH-1:0] res_lo
);

   // Multiply: acc = {partial product, remaining multiplier bits}.
   // Divide:   acc = {partial remainder, dividend bits shifting into quotient bits}.
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opb_q, opb_d;
   logic               is_div_q, is_div_d;
   logic               quo_neg_q, quo_neg_d;
   logic               rem_neg_q, rem_neg_d;

   logic               is_div, is_signed, dbz;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH:0]     sum, shifted, diff;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quo, rem;

   // Operand latch on issue, then one multiply or divide step per RUN cycle
   always_comb begin
      is_div    = op[1];
      is_signed = ~op[0];
      dbz       = is_div && (rt_data == '0);
      // A zero divisor keeps the raw dividend so the remainder comes out as rs_data unchanged.
      a_mag     = (is_signed && !dbz) ? abs_val(rs_data) : rs_data;
      b_mag     = is_signed ? abs_val(rt_data) : rt_data;

      sum       = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opb_q : '0)};
      shifted   = acc_q[2*WIDTH-1:WIDTH-1];
      diff      = shifted - {1'b0, opb_q};

      acc_d     = acc_q;
      opb_d     = opb_q;
      is_div_d  = is_div_q;
      quo_neg_d = quo_neg_q;
      rem_neg_d = rem_neg_q;
      if (load) begin
         acc_d     = {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
         opb_d     = is_div ? b_mag : a_mag;
         is_div_d  = is_div;
         quo_neg_d = is_signed && !dbz && (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
         rem_neg_d = is_signed && !dbz && rs_data[WIDTH-1];
      end else if (step) begin
         if (!is_div_q)
            acc_d = {sum, acc_q[WIDTH-1:1]};
         else if (!diff[WIDTH])
            acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
         else
            acc_d = {shifted[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end
   end

   // Accumulator and operand registers
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         acc_q     <= '0;
         opb_q     <= '0;
         is_div_q  <= 1'b0;
         quo_neg_q <= 1'b0;
         rem_neg_q <= 1'b0;
      end else begin
         acc_q     <= acc_d;
         opb_q     <= opb_d;
         is_div_q  <= is_div_d;
         quo_neg_q <= quo_neg_d;
         rem_neg_q <= rem_neg_d;
      end
   end

   // Sign fixup of the finished magnitudes, selected onto HI/LO
   always_comb begin
      prod   = quo_neg_q ? -acc_q : acc_q;
      quo    = quo_neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      rem    = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
      res_hi = is_div_q ? rem : prod[2*WIDTH-1:WIDTH];
      res_lo = is_div_q ? quo : prod[WIDTH-1:0];
   end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative multiply/divide unit with HI/LO registers and pipeline stall
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int ITERATIONS = WIDTH
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             start,
   input  muldiv_op_e       op,
   input  logic [WIDTH-1:0] rs_data,
   input  logic [WIDTH-1:0] rt_data,
   input  logic             read_hi,
   input  logic             read_lo,
   input  logic             write_hi,
   input  logic             write_lo,
   input  logic             flush,
   output logic             busy,
   output logic             stall,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(ITERATIONS);

   muldiv_state_e    state_q, state_d;
   logic [CW-1:0]    counter_q, counter_d;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
   logic             done_q, done_d;
   logic             load, step;
   logic [WIDTH-1:0] res_hi, res_lo;

   muldiv_datapath u_datapath (
      .clk     (clk),
      .nrst    (nrst),
      .load    (load),
      .step    (step),
      .op      (op),
      .rs_data (rs_data),
      .rt_data (rt_data),
      .res_hi  (res_hi),
      .res_lo  (res_lo)
   );

   // State, step counter, HI/LO and done registers
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q   <= IDLE;
         counter_q <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         counter_q <= counter_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         done_q    <= done_d;
      end
   end

   // Next state: flush beats start in IDLE and aborts RUN/FIX
   always_comb begin
      state_d   = state_q;
      counter_d = counter_q;
      case (state_q)
         IDLE: begin
            if (start && !flush) begin
               state_d   = RUN;
               counter_d = CW'(ITERATIONS - 1);
            end
         end
         RUN: begin
            if (flush)
               state_d = IDLE;
            else if (counter_q == '0)
               state_d = FIX;
            else
               counter_d = counter_q - CW'(1);
         end
         FIX:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs: busy, stall and datapath strobes
   always_comb begin
      busy  = (state_q != IDLE);
      stall = busy && (start || read_hi || read_lo || write_hi || write_lo);
      load  = (state_q == IDLE) && start && !flush;
      step  = (state_q == RUN) && !flush;
   end

   // HI/LO update: operation result on FIX, MTHI/MTLO when idle and no start
   always_comb begin
      hi_d   = hi_q;
      lo_d   = lo_q;
      done_d = 1'b0;
      if (state_q == FIX && !flush) begin
         hi_d   = res_hi;
         lo_d   = res_lo;
         done_d = 1'b1;
      end else if (state_q == IDLE && !start) begin
         if (write_hi) hi_d = rs_data;
         if (write_lo) lo_d = rs_data;
      end
   end

   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

   // Decode never issues a mul/div together with MTHI/MTLO
   start_mt_exclusive: assert property (@(posedge clk) disable iff (!nrst)
      !(state_q == IDLE && start && (write_hi || write_lo)));

endmodule
